panel_exec: RTL and testbench
=============================

# panel_exec

Front-panel command executor: the CPU-side responder to the front-panel switch sequencer. It accepts the debounced, trigger-qualified switch pulses (clear, extended address load, address load, deposit, examine, continue) and carries out each command: loads PC and field registers from the switch register, deposits or examines memory with PC auto-increment, and issues one-cycle clear/run requests to the CPU core. It sits between the front-panel sequencer and the memory arbiter and drives the MA/MB lamp registers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: memory-ack watchdog limit; used only with PANEL_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- triggerd  in  1  command strobe from the sequencer; held high for several cycles per command.
- cleard, extd_addrd, addr_loadd, depd, examd, contd  in  1 each  command qualifiers, valid while triggerd=1.
- sr  in  [0:11]  switch register; bit 0 is the MSB.
- ifsr, dfsr  in  [0:2]  instruction-field and data-field switches.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  [0:14]  {ifr, pc}.
- mem_wdata  out  [0:11]  = sr latched at command capture.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  [0:11]  read data.
- pc  out  [0:11]  program counter.
- ifr, dfr  out  [0:2]  instruction and data field registers.
- ma  out  [0:14]  memory-address lamp register.
- mb  out  [0:11]  memory-buffer lamp register.
- clear_req  out  1  one-cycle pulse: clear AC, link and flags.
- run_req  out  1  one-cycle pulse: start or continue execution.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- mem_err  out  1  sticky timeout flag; stuck at 0 without PANEL_MEM_TIMEOUT_EN.

## Operation
- Reset values: all outputs 0. pc, ifr, dfr, ma and mb are 0. State is IDLE.
- Command capture: a rising edge of triggerd is detected against a registered copy, trig_q. In IDLE, that edge latches one command and sr.
- Priority when several qualifiers are set: clear > extd_addr > addr_load > dep > exam > cont. An edge with no qualifier set is ignored, with no done pulse.
- Edges arriving while busy=1 are ignored and never queued.
- States: IDLE, EXEC, MEM, FIN.
  - IDLE to EXEC on a captured command.
  - EXEC to MEM for dep and exam; EXEC to FIN for all other commands.
  - MEM to FIN on mem_ack, or on timeout.
  - FIN to IDLE unconditionally.
- Command actions:
  - clear: clear_req pulses during EXEC.
  - extd_addr: ifr ← ifsr and dfr ← dfsr, registered at the end of EXEC.
  - addr_load: pc ← sr and ma ← {ifr, sr}.
  - dep: write sr to {ifr, pc}. On ack: mb ← sr, ma ← {ifr, pc}, pc ← pc+1.
  - exam: read {ifr, pc}. On ack: mb ← mem_rdata, ma ← {ifr, pc}, pc ← pc+1.
  - cont: run_req pulses during EXEC.
- Arithmetic: pc increments modulo 2^12 (7777 → 0000). ifr never changes on wrap.
- busy is high in EXEC, MEM and FIN. done pulses in FIN.

## Timing
- Cycle T: triggerd=1 and trig_q=0. The state is EXEC from T+1.
- Register-only commands: the result is visible at T+2. done=1 at T+2. busy falls at T+3.
- clear_req and run_req are high exactly in cycle T+1.
- Memory commands: mem_req, mem_we and mem_addr are asserted from T+2 and stay stable until the ack cycle. mem_req drops in the cycle after ack. Results and done appear in the cycle after ack.
- Minimum deposit or examine latency is 3 cycles from trigger to done, with ack in the first MEM cycle.
- Reset asserted mid-command aborts immediately: all outputs go to reset values, including mem_req.

## Configuration
- PANEL_MEM_TIMEOUT_EN defined: MEM counts cycles without ack.
  - After TIMEOUT_CYCLES the command is abandoned: mem_req drops, mem_err sets, and pc, ma and mb are unchanged. The block passes through FIN, so done still pulses.
  - mem_err clears only on reset or on a clear command.
- PANEL_MEM_TIMEOUT_EN undefined: MEM waits for ack indefinitely. mem_err is tied to 0 and no counter is built.

## Structure
- The shared package panel_pkg holds:
  - the command encoding (CMD_NONE, CMD_CLEAR, CMD_EXTD, CMD_ALOAD, CMD_DEP, CMD_EXAM, CMD_CONT);
  - the state encoding;
  - the widths ADDR_W=15 and WORD_W=12.
- One sub-module, panel_mem_port, owns the req/ack handshake, the write-data hold and the optional watchdog.
- The command decode and the FSM stay in panel_exec.

## Test plan
- Load address: sr=0200 (octal) with addr_load and a trigger edge → pc=0200 and ma=00200 at T+2, with one done pulse.
- Extended address then deposit: ifsr=3, dfsr=5, sr=1234 with dep, ack delayed 4 cycles → mem_addr=30200, mem_we=1 and mem_wdata=1234 held until ack; then mb=1234 and pc=0201.
- Examine wrap: pc=7777, ifr=1, mem_rdata=4321 → read at address 17777; mb=4321, ma=17777, pc=0000, ifr stays 1.
- Priority and busy: clear and cont set together → clear_req pulses, run_req stays 0. A second trigger edge during a stalled dep is ignored.
- Continue: contd with a trigger → run_req high for exactly one cycle at T+1. A trigger held high for 4 cycles produces one command only.
- Timeout (PANEL_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8): exam with no ack → mem_req drops after 8 cycles, mem_err=1, pc unchanged, done pulses. A following clear command resets mem_err to 0.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared types for the front-panel command executor: command and state encodings,
// datapath widths, and the qualifier priority decoder.
package panel_pkg;

  localparam int ADDR_W  = 15;
  localparam int WORD_W  = 12;
  localparam int FIELD_W = 3;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_EXTD,
    CMD_ALOAD,
    CMD_DEP,
    CMD_EXAM,
    CMD_CONT
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_FIN
  } state_e;

  // Earlier arguments win when several qualifiers arrive together
  function automatic cmd_e decode_cmd(input logic clr, input logic extd, input logic aload,
                                      input logic dep, input logic exam, input logic cont);
    if (clr)        return CMD_CLEAR;
    else if (extd)  return CMD_EXTD;
    else if (aload) return CMD_ALOAD;
    else if (dep)   return CMD_DEP;
    else if (exam)  return CMD_EXAM;
    else if (cont)  return CMD_CONT;
    else            return CMD_NONE;
  endfunction

endpackage

// File: rtl/panel_mem_port.sv
// Memory-side handshake for panel deposit/examine: holds req/we/addr/wdata until ack.
// With PANEL_MEM_TIMEOUT_EN defined, a watchdog abandons a request after TIMEOUT_CYCLES.
module panel_mem_port
  import panel_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              we_in,
  input  logic [0:ADDR_W-1] addr_in,
  input  logic [0:WORD_W-1] wdata_in,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [0:ADDR_W-1] mem_addr,
  output logic [0:WORD_W-1] mem_wdata,
  output logic              xfer_done,
  output logic              timeout
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= we_in;
      mem_addr  <= addr_in;
      mem_wdata <= wdata_in;
    end else if (mem_req && (mem_ack || timeout)) begin
      mem_req <= 1'b0;
    end
  end

  assign xfer_done = mem_req && mem_ack;

`ifdef PANEL_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  // Counts unacknowledged request cycles; fires in the last allowed cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (start) begin
      wd_cnt <= '0;
    end else if (mem_req && !mem_ack) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = mem_req && !mem_ack && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/panel_exec.sv
// Front-panel command executor: captures trigger edges, runs register and memory commands.
// Optional memory-ack watchdog enabled by defining PANEL_MEM_TIMEOUT_EN.
module panel_exec
  import panel_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               triggerd,
  input  logic               cleard,
  input  logic               extd_addrd,
  input  logic               addr_loadd,
  input  logic               depd,
  input  logic               examd,
  input  logic               contd,
  input  logic [0:WORD_W-1]  sr,
  input  logic [0:FIELD_W-1] ifsr,
  input  logic [0:FIELD_W-1] dfsr,
  output logic               mem_req,
  output logic               mem_we,
  output logic [0:ADDR_W-1]  mem_addr,
  output logic [0:WORD_W-1]  mem_wdata,
  input  logic               mem_ack,
  input  logic [0:WORD_W-1]  mem_rdata,
  output logic [0:WORD_W-1]  pc,
  output logic [0:FIELD_W-1] ifr,
  output logic [0:FIELD_W-1] dfr,
  output logic [0:ADDR_W-1]  ma,
  output logic [0:WORD_W-1]  mb,
  output logic               clear_req,
  output logic               run_req,
  output logic               busy,
  output logic               done,
  output logic               mem_err
);

  state_e            state;
  cmd_e              cmd;
  cmd_e              cmd_in;
  logic              trig_q;
  logic [0:WORD_W-1] sr_q;
  logic              mem_start;
  logic              xfer_done;
  logic              timeout;

  assign cmd_in    = decode_cmd(cleard, extd_addrd, addr_loadd, depd, examd, contd);
  assign mem_start = (state == ST_EXEC) && ((cmd == CMD_DEP) || (cmd == CMD_EXAM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trig_q <= 1'b0;
    else        trig_q <= triggerd;
  end

  // Pulses default low each cycle; busy spans EXEC through FIN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cmd       <= CMD_NONE;
      sr_q      <= '0;
      pc        <= '0;
      ifr       <= '0;
      dfr       <= '0;
      ma        <= '0;
      mb        <= '0;
      clear_req <= 1'b0;
      run_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      clear_req <= 1'b0;
      run_req   <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (triggerd && !trig_q && (cmd_in != CMD_NONE)) begin
            cmd       <= cmd_in;
            sr_q      <= sr;
            state     <= ST_EXEC;
            busy      <= 1'b1;
            clear_req <= (cmd_in == CMD_CLEAR);
            run_req   <= (cmd_in == CMD_CONT);
          end
        end
        ST_EXEC: begin
          case (cmd)
            CMD_EXTD: begin
              ifr <= ifsr;
              dfr <= dfsr;
            end
            CMD_ALOAD: begin
              pc <= sr_q;
              ma <= {ifr, sr_q};
            end
            default: ;
          endcase
          if ((cmd == CMD_DEP) || (cmd == CMD_EXAM)) begin
            state <= ST_MEM;
          end else begin
            state <= ST_FIN;
            done  <= 1'b1;
          end
        end
        ST_MEM: begin
          if (xfer_done) begin
            mb    <= (cmd == CMD_DEP) ? sr_q : mem_rdata;
            ma    <= {ifr, pc};
            pc    <= pc + 1'b1;
            state <= ST_FIN;
            done  <= 1'b1;
          end else if (timeout) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PANEL_MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        mem_err <= 1'b0;
    else if ((state == ST_EXEC) && (cmd == CMD_CLEAR)) mem_err <= 1'b0;
    else if (timeout)                                  mem_err <= 1'b1;
  end
`else
  assign mem_err = 1'b0;
`endif

  panel_mem_port #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_port (
    .clk      (clk),
    .reset    (reset),
    .start    (mem_start),
    .we_in    (cmd == CMD_DEP),
    .addr_in  ({ifr, pc}),
    .wdata_in (sr_q),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .xfer_done(xfer_done),
    .timeout  (timeout)
  );

endmodule

// File: tb/tb_panel_exec.sv
// Self-checking bench for panel_exec: register state is scoreboarded at every done pulse,
// handshake and pulse timing are checked inline by each scenario task.
module tb_panel_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        triggerd, cleard, extd_addrd, addr_loadd, depd, examd, contd;
  logic [0:11] sr;
  logic [0:2]  ifsr, dfsr;
  logic        mem_req, mem_we, mem_ack;
  logic [0:14] mem_addr, ma;
  logic [0:11] mem_wdata, mem_rdata, pc, mb;
  logic [0:2]  ifr, dfr;
  logic        clear_req, run_req, busy, done, mem_err;

  localparam logic [5:0] Q_CLR  = 6'b100000;
  localparam logic [5:0] Q_EXTD = 6'b010000;
  localparam logic [5:0] Q_ALD  = 6'b001000;
  localparam logic [5:0] Q_DEP  = 6'b000100;
  localparam logic [5:0] Q_EXAM = 6'b000010;
  localparam logic [5:0] Q_CONT = 6'b000001;

  typedef struct packed {
    logic [0:11] pc;
    logic [0:2]  ifr;
    logic [0:2]  dfr;
    logic [0:14] ma;
    logic [0:11] mb;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;
  int trig_hold = 0;

  logic [0:11] m_pc;
  logic [0:2]  m_ifr, m_dfr;
  logic [0:14] m_ma;
  logic [0:11] m_mb;

  always #5 clk = ~clk;

  panel_exec #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .triggerd(triggerd), .cleard(cleard),
    .extd_addrd(extd_addrd), .addr_loadd(addr_loadd), .depd(depd), .examd(examd),
    .contd(contd), .sr(sr), .ifsr(ifsr), .dfsr(dfsr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .pc(pc), .ifr(ifr), .dfr(dfr), .ma(ma), .mb(mb),
    .clear_req(clear_req), .run_req(run_req), .busy(busy), .done(done), .mem_err(mem_err)
  );

  // Scoreboard: every done pulse must match the oldest expected register snapshot
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_unexpected_done: got done=1, expected no command pending");
      end else begin
        e = sbq.pop_front();
        if (pc !== e.pc) begin miscompares++; $display("[TB] FAIL sb_pc: got %o, expected %o", pc, e.pc); end
        vectors++;
        if (ifr !== e.ifr) begin miscompares++; $display("[TB] FAIL sb_ifr: got %o, expected %o", ifr, e.ifr); end
        vectors++;
        if (dfr !== e.dfr) begin miscompares++; $display("[TB] FAIL sb_dfr: got %o, expected %o", dfr, e.dfr); end
        vectors++;
        if (ma !== e.ma) begin miscompares++; $display("[TB] FAIL sb_ma: got %o, expected %o", ma, e.ma); end
        vectors++;
        if (mb !== e.mb) begin miscompares++; $display("[TB] FAIL sb_mb: got %o, expected %o", mb, e.mb); end
      end
    end
  end

  function automatic void push_exp();
    exp_t t;
    t.pc = m_pc; t.ifr = m_ifr; t.dfr = m_dfr; t.ma = m_ma; t.mb = m_mb;
    sbq.push_back(t);
  endfunction

  task automatic tick();
    @(negedge clk);
    if (trig_hold > 0) begin
      trig_hold--;
      if (trig_hold == 0) begin
        triggerd = 1'b0;
        {cleard, extd_addrd, addr_loadd, depd, examd, contd} = 6'b0;
      end
    end
  endtask

  task automatic fire(input logic [5:0] q, input int hold);
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = q;
    triggerd = 1'b1;
    trig_hold = hold;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({pc, ifr, dfr, ma, mb} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: got pc=%o ifr=%o dfr=%o ma=%o mb=%o, expected all 0", pc, ifr, dfr, ma, mb);
    end
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mem: got req=%b we=%b addr=%o wdata=%o, expected all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    vectors++;
    if ({clear_req, run_req, busy, done, mem_err} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, expected 00000", {clear_req, run_req, busy, done, mem_err});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_addr_load();
    sr = 12'o0200;
    m_pc = 12'o0200; m_ma = {m_ifr, 12'o0200}; push_exp();
    fire(Q_ALD, 3);
    tick();
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL aload_t1: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    tick();
    vectors++;
    if (pc !== 12'o0200 || ma !== 15'o00200 || done !== 1'b1) begin
      miscompares++; $display("[TB] FAIL aload_t2: got pc=%o ma=%o done=%b, expected 0200 00200 1", pc, ma, done);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL aload_t3: got busy=%b done=%b, expected 0 0", busy, done);
    end
    tick();
  endtask

  task automatic test_ext_deposit();
    logic ok;
    int runs;
    ifsr = 3'd3; dfsr = 3'd5;
    m_ifr = 3'd3; m_dfr = 3'd5; push_exp();
    fire(Q_EXTD, 2);
    tick(); tick();
    vectors++;
    if (ifr !== 3'd3 || dfr !== 3'd5) begin
      miscompares++; $display("[TB] FAIL extd_fields: got ifr=%o dfr=%o, expected 3 5", ifr, dfr);
    end
    tick(); tick();
    sr = 12'o1234;
    m_mb = 12'o1234; m_ma = {m_ifr, m_pc}; m_pc = m_pc + 1'b1; push_exp();
    fire(Q_DEP, 1);
    tick();
    ok = 1'b1; runs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'o30200 || mem_wdata !== 12'o1234 || done !== 1'b0)
        ok = 1'b0;
      if (run_req === 1'b1) runs++;
      if (i == 0) sr = 12'o7070;
      if (i == 1) fire(Q_CONT, 3);
      if (i == 4) mem_ack = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL dep_hold: got req=%b we=%b addr=%o wdata=%o, expected 1 1 30200 1234 stable", mem_req, mem_we, mem_addr, mem_wdata);
    end
    tick();
    mem_ack = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || done !== 1'b1 || pc !== 12'o0201 || mb !== 12'o1234) begin
      miscompares++; $display("[TB] FAIL dep_result: got req=%b done=%b pc=%o mb=%o, expected 0 1 0201 1234", mem_req, done, pc, mb);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (run_req === 1'b1) runs++;
    end
    vectors++;
    if (runs != 0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL dep_ignore_edge: got run pulses=%0d busy=%b, expected 0 0", runs, busy);
    end
    sr = 12'o0;
  endtask

  task automatic test_exam_wrap();
    ifsr = 3'd1; dfsr = 3'd0;
    m_ifr = 3'd1; m_dfr = 3'd0; push_exp();
    fire(Q_EXTD, 1);
    tick(); tick(); tick();
    sr = 12'o7777;
    m_pc = 12'o7777; m_ma = 15'o17777; push_exp();
    fire(Q_ALD, 1);
    tick(); tick(); tick();
    m_mb = 12'o4321; m_ma = 15'o17777; m_pc = 12'o0000; push_exp();
    fire(Q_EXAM, 2);
    tick(); tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'o17777) begin
      miscompares++; $display("[TB] FAIL exam_req: got req=%b we=%b addr=%o, expected 1 0 17777", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 12'o4321;
    tick();
    mem_ack = 1'b0; mem_rdata = 12'o0;
    vectors++;
    if (done !== 1'b1 || pc !== 12'o0000 || ifr !== 3'd1 || mb !== 12'o4321) begin
      miscompares++; $display("[TB] FAIL exam_wrap: got done=%b pc=%o ifr=%o mb=%o, expected 1 0000 1 4321", done, pc, ifr, mb);
    end
    tick(); tick();
  endtask

  task automatic test_priority();
    logic quiet;
    push_exp();
    fire(Q_CLR | Q_CONT, 2);
    tick();
    vectors++;
    if (clear_req !== 1'b1 || run_req !== 1'b0) begin
      miscompares++; $display("[TB] FAIL prio_t1: got clear_req=%b run_req=%b, expected 1 0", clear_req, run_req);
    end
    tick();
    vectors++;
    if (clear_req !== 1'b0 || run_req !== 1'b0 || done !== 1'b1) begin
      miscompares++; $display("[TB] FAIL prio_t2: got clear_req=%b run_req=%b done=%b, expected 0 0 1", clear_req, run_req, done);
    end
    tick(); tick();
    fire(6'b0, 2);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy !== 1'b0 || clear_req !== 1'b0 || run_req !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++; $display("[TB] FAIL no_qual_edge: got busy/pulse activity, expected none");
    end
  endtask

  task automatic test_continue();
    int runs;
    logic first;
    push_exp();
    fire(Q_CONT, 4);
    runs = 0; first = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (run_req === 1'b1) begin
        runs++;
        if (i == 1) first = 1'b1;
      end
    end
    vectors++;
    if (runs != 1 || !first) begin
      miscompares++; $display("[TB] FAIL cont_pulse: got %0d pulses (at T+1=%b), expected 1 at T+1", runs, first);
    end
  endtask

`ifdef PANEL_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    logic seen, dropped;
    push_exp();
    fire(Q_EXAM, 2);
    cnt = 0; seen = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      tick();
      if (mem_req === 1'b1) begin cnt++; seen = 1'b1; end
      else if (seen) dropped = 1'b1;
    end
    vectors++;
    if (!dropped || cnt != 8) begin
      miscompares++; $display("[TB] FAIL timeout_len: got dropped=%b req cycles=%0d, expected 1 8", dropped, cnt);
    end
    vectors++;
    if (done !== 1'b1 || mem_err !== 1'b1 || pc !== m_pc) begin
      miscompares++; $display("[TB] FAIL timeout_flags: got done=%b mem_err=%b pc=%o, expected 1 1 %o", done, mem_err, pc, m_pc);
    end
    tick();
    push_exp();
    fire(Q_CLR, 1);
    tick(); tick();
    vectors++;
    if (mem_err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL timeout_clear: got mem_err=%b, expected 0", mem_err);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    logic ok;
    m_mb = 12'o0066; m_ma = {m_ifr, m_pc}; m_pc = m_pc + 1'b1; push_exp();
    fire(Q_EXAM, 1);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req !== 1'b1 || mem_err !== 1'b0 || done !== 1'b0) ok = 1'b0;
      if (i == 19) begin mem_ack = 1'b1; mem_rdata = 12'o0066; end
    end
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL long_wait: got req=%b mem_err=%b done=%b, expected 1 0 0 throughout", mem_req, mem_err, done);
    end
    tick();
    mem_ack = 1'b0; mem_rdata = 12'o0;
    vectors++;
    if (done !== 1'b1 || mem_err !== 1'b0 || mb !== 12'o0066) begin
      miscompares++; $display("[TB] FAIL long_result: got done=%b mem_err=%b mb=%o, expected 1 0 0066", done, mem_err, mb);
    end
    tick();
  endtask
`endif

  task automatic test_reset_abort();
    sr = 12'o5555;
    push_exp();
    fire(Q_DEP, 1);
    tick(); tick();
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++; $display("[TB] FAIL abort_pre: got mem_req=%b, expected 1", mem_req);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({mem_req, busy, done, pc, ifr, dfr, ma, mb} !== '0) begin
      miscompares++; $display("[TB] FAIL abort_reset: got req=%b busy=%b pc=%o ifr=%o ma=%o mb=%o, expected all 0", mem_req, busy, pc, ifr, ma, mb);
    end
    sbq.delete();
    m_pc = '0; m_ifr = '0; m_dfr = '0; m_ma = '0; m_mb = '0;
    tick();
    reset = 1'b1;
    tick(); tick();
  endtask

  initial begin
    reset = 1'b0;
    triggerd = 1'b0;
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = 6'b0;
    sr = '0; ifsr = '0; dfsr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    m_pc = '0; m_ifr = '0; m_dfr = '0; m_ma = '0; m_mb = '0;
    test_reset();
    test_addr_load();
    test_ext_deposit();
    test_exam_wrap();
    test_priority();
    test_continue();
`ifdef PANEL_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_abort();
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++; $display("[TB] FAIL sb_leftover: got %0d pending results, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
